// File: rtl/ecall_io_unit.sv
// ecall_io_unit: environment-call I/O front end sitting beside the register file.
//   a7==5 (read) : holds the PC until a debounced confirm press, then drives the
//                  captured switch value on io_input.
//   a7==1 (print): captures a0 and shows it as 8 hex digits on a multiplexed
//                  7-segment display.
// Optional feature macro: IO_ECHO_EN -- while a read is waiting, the display scan
//   shows the live synced switches instead of the display register.
// Ports:
//   clk          in   1     system clock, rising edge
//   reset        in   1     asynchronous, active-low
//   ecall        in   1     current instruction is ecall
//   a7           in   32    service number (x17)
//   a0           in   32    print argument (x10)
//   sw           in   SW_W  raw switch inputs
//   btn_confirm  in   1     raw confirm button, active-high, bouncy
//   io_input     out  32    captured input value for the register file
//   stall        out  1     1 = PC must hold (combinational)
//   seg_an       out  8     digit enables, active-low, one-hot-low
//   seg_cat      out  8     segments {dp,g..a}, active-low, dp always off
module ecall_io_unit #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_DIV        = 50_000,
  parameter int SW_W            = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ecall,
  input  logic [31:0]     a7,
  input  logic [31:0]     a0,
  input  logic [SW_W-1:0] sw,
  input  logic            btn_confirm,
  output logic [31:0]     io_input,
  output logic            stall,
  output logic [7:0]      seg_an,
  output logic [7:0]      seg_cat
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, DONE} state_t;

  // Active-low glyphs {g..a} for hex digits 0-F.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'h40;  4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;  4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;  4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;  4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;  4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;  4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;  4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;  default: hex_glyph = 7'h0E;
    endcase
  endfunction

  logic            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [SW_W-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  state_t          state_q, state_d;
  logic [31:0]     io_q, io_d;
  logic [31:0]     disp_q, disp_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]      idx_q, idx_d;

  logic        press;
  logic        read_req, print_req;
  logic        stall_raw;
  logic [31:0] sw_ext;
  logic [31:0] shown;

  assign read_req  = ecall && (a7 == 32'd5);
  assign print_req = ecall && (a7 == 32'd1);
  assign sw_ext    = 32'(sw_s2_q);

  // Synchronizers and debouncer. press fires on the same edge the stable level
  // rises, so the FSM captures sw together with the level flip.
  always_comb begin
    btn_s1_d = btn_confirm;
    btn_s2_d = btn_s1_q;
    sw_s1_d  = sw;
    sw_s2_d  = sw_s1_q;
    stable_d = stable_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (btn_s2_q != stable_q) begin
      if (db_cnt_q == DB_MAX) begin
        stable_d = btn_s2_q;
        press    = btn_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Service FSM.
  always_comb begin
    state_d   = state_q;
    io_d      = io_q;
    disp_d    = disp_q;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_req) begin
          stall_raw = 1'b1;
          state_d   = WAIT_PRESS;
        end else if (print_req) begin
          disp_d = a0;
        end
      end
      WAIT_PRESS: begin
        stall_raw = 1'b1;
        if (press) begin
          io_d    = sw_ext;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        stall_raw = 1'b1;
        if (!stable_q) state_d = DONE;
      end
      // Stall low here lets the PC step past exactly one ecall.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The IDLE read-request term is combinational on ecall; gate with reset so
  // stall is low the moment reset asserts.
  assign stall = stall_raw & reset;

  // Display scan.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_MAX) begin
      div_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

`ifdef IO_ECHO_EN
  assign shown = ((state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE)) ? sw_ext : disp_q;
`else
  assign shown = disp_q;
`endif

  assign seg_an   = ~(8'h01 << idx_q);
  assign seg_cat  = {1'b1, hex_glyph(shown[4*idx_q +: 4])};
  assign io_input = io_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= IDLE;
      io_q     <= '0;
      disp_q   <= '0;
      div_q    <= '0;
      idx_q    <= '0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      sw_s1_q  <= sw_s1_d;
      sw_s2_q  <= sw_s2_d;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      io_q     <= io_d;
      disp_q   <= disp_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_ecall_io_unit.sv
// Testbench for ecall_io_unit (DEBOUNCE_CYCLES=4, SCAN_DIV=2, SW_W=8).
// A behavioural model tracks the service phase, the debounced button level,
// the captured input, the display value and the scan position (derived from
// the number of clock edges since reset).
module tb_ecall_io_unit;
  localparam int DC = 4;
  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ecall = 1'b0;
  logic [31:0] a7 = '0;
  logic [31:0] a0 = '0;
  logic [7:0]  sw = '0;
  logic        btn = 1'b0;
  logic [31:0] io_input;
  logic        stall;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  always #5 clk = ~clk;

  ecall_io_unit #(.DEBOUNCE_CYCLES(DC), .SCAN_DIV(SD), .SW_W(8)) dut (
    .clk(clk), .reset(reset), .ecall(ecall), .a7(a7), .a0(a0), .sw(sw),
    .btn_confirm(btn), .io_input(io_input), .stall(stall),
    .seg_an(seg_an), .seg_cat(seg_cat)
  );

  int n_cmp = 0;
  int n_bad = 0;

  localparam int M_IDLE = 0, M_WP = 1, M_WR = 2, M_DONE = 3;
  int          m_phase;
  logic        m_b1, m_b2, m_stable;
  logic [7:0]  m_s1, m_s2;
  int          m_run;
  logic [31:0] m_io, m_disp;
  int          m_edges;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = M_IDLE; m_b1 = 0; m_b2 = 0; m_stable = 0; m_s1 = 0; m_s2 = 0;
    m_run = 0; m_io = 0; m_disp = 0; m_edges = 0;
  endtask

  // One clock edge of the model, using the inputs held across the edge.
  task automatic m_step();
    logic sync, old_st, pr;
    logic [7:0] swv;
    sync = m_b2; swv = m_s2; old_st = m_stable; pr = 1'b0;
    if (sync != m_stable) begin
      m_run++;
      if (m_run == DC) begin
        m_stable = sync; m_run = 0; pr = sync;
      end
    end else begin
      m_run = 0;
    end
    case (m_phase)
      M_IDLE: begin
        if (ecall && a7 == 32'd5) m_phase = M_WP;
        else if (ecall && a7 == 32'd1) m_disp = a0;
      end
      M_WP: if (pr) begin m_io = {24'b0, swv}; m_phase = M_WR; end
      M_WR: if (!old_st) m_phase = M_DONE;
      default: m_phase = M_IDLE;
    endcase
    m_b2 = m_b1; m_b1 = btn; m_s2 = m_s1; m_s1 = sw;
    m_edges++;
  endtask

  function automatic int cur_idx();
    return (m_edges / SD) % 8;
  endfunction

  task automatic compare_all();
    int idx;
    logic es;
    logic [7:0] ean;
    logic [31:0] shown;
    idx = cur_idx();
    es = reset && ((m_phase == M_IDLE && ecall && a7 == 32'd5) ||
                   m_phase == M_WP || m_phase == M_WR);
`ifdef IO_ECHO_EN
    shown = (m_phase == M_WP || m_phase == M_WR) ? {24'b0, m_s2} : m_disp;
`else
    shown = m_disp;
`endif
    ean = ~(8'h01 << idx);
    chk("stall", {31'b0, stall}, {31'b0, es});
    chk("io_input", io_input, m_io);
    chk("seg_an", {24'b0, seg_an}, {24'b0, ean});
    chk("seg_cat", {24'b0, seg_cat}, {24'b0, glyph[shown[4*idx +: 4]]});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait (bounded) for the model to reach DONE, check the response there, then drop ecall.
  task automatic finish_read(input string nm, input logic [31:0] exp_io);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      tick();
      if (m_phase == M_DONE) begin
        seen = 1'b1;
        chk({nm, "_done_stall"}, {31'b0, stall}, 32'd0);
        chk({nm, "_value"}, io_input, exp_io);
        ecall = 1'b0;
      end else begin
        chk({nm, "_wait_stall"}, {31'b0, stall}, 32'd1);
      end
    end
    chk({nm, "_done_reached"}, {31'b0, seen}, 32'd1);
    ecall = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int btn_left;
    logic [31:0] a7_sel [4];
    m_reset();
    run(3);
    chk("reset_seg_an", {24'b0, seg_an}, 32'hFE);
    chk("reset_io", io_input, 32'h0);
    @(negedge clk) reset = 1'b1;

    // Print 1234ABCD; walk the scan over two full rounds.
    ecall = 1'b1; a7 = 32'd1; a0 = 32'h1234ABCD;
    #1 chk("print_stall", {31'b0, stall}, 32'd0);
    tick();
    ecall = 1'b0;
    for (int i = 0; i < 8 * SD * 2; i++) begin
      tick();
      chk("an_walk", {24'b0, seg_an}, {24'b0, an_tab[cur_idx()]});
      if (cur_idx() == 0) chk("digit0_D", {24'b0, seg_cat}, 32'hA1);
      if (cur_idx() == 7) chk("digit7_1", {24'b0, seg_cat}, 32'hF9);
    end

    // Unknown service: no stall, nothing changes.
    ecall = 1'b1; a7 = 32'd7; a0 = 32'hFFFF_FFFF;
    #1 chk("a7_7_stall", {31'b0, stall}, 32'd0);
    tick();
    ecall = 1'b0;
    for (int i = 0; i < 8 * SD; i++) begin
      tick();
      if (cur_idx() == 0) chk("a7_7_digit0", {24'b0, seg_cat}, 32'hA1);
    end
    chk("a7_7_io", io_input, 32'h0);

    // Read with a bouncy button, then a clean press and release.
    sw = 8'hA5; ecall = 1'b1; a7 = 32'd5;
    #1 chk("read_stall", {31'b0, stall}, 32'd1);
    for (int r = 0; r < 4; r++) begin
      btn = 1'b1; tick(); chk("bounce_stall", {31'b0, stall}, 32'd1); tick();
      btn = 1'b0; tick(); chk("bounce_stall", {31'b0, stall}, 32'd1); tick();
    end
    chk("bounce_no_capture", io_input, 32'h0);
    btn = 1'b1; run(8);
    chk("held_stall", {31'b0, stall}, 32'd1);
    chk("captured_A5", io_input, 32'h0000_00A5);
    btn = 1'b0;
    finish_read("read1", 32'h0000_00A5);
    chk("after_read_stall", {31'b0, stall}, 32'd0);

    // Button already held when the read arrives: needs release and a fresh press.
    btn = 1'b1; run(8);
    sw = 8'h5A; ecall = 1'b1; a7 = 32'd5;
    run(6);
    chk("prehold_stall", {31'b0, stall}, 32'd1);
    btn = 1'b0; run(10);
    chk("prehold_no_capture", io_input, 32'h0000_00A5);
    chk("prehold_stall2", {31'b0, stall}, 32'd1);
    btn = 1'b1; run(8);
    btn = 1'b0;
    finish_read("read2", 32'h0000_005A);

    // Reset in the middle of a wait.
    sw = 8'h77; ecall = 1'b1; a7 = 32'd5;
    run(3);
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_io", io_input, 32'h0);
    chk("rst_seg_an", {24'b0, seg_an}, 32'hFE);
    run(3);
    ecall = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick();
    chk("post_rst_stall", {31'b0, stall}, 32'd0);
    ecall = 1'b1; a7 = 32'd1; a0 = 32'hCAFE_0001;
    tick();
    ecall = 1'b0;
    run(8 * SD);

    // Randomized traffic.
    a7_sel[0] = 32'd1; a7_sel[1] = 32'd5; a7_sel[2] = 32'd7; a7_sel[3] = 32'd0;
    btn_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if (btn_left == 0) begin
        btn = 1'($urandom_range(0, 1));
        btn_left = $urandom_range(1, 7);
      end else begin
        btn_left--;
      end
      if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
      if (m_phase == M_IDLE || m_phase == M_DONE) begin
        ecall = ($urandom_range(0, 5) == 0);
        a7 = ($urandom_range(0, 9) == 0) ? $urandom : a7_sel[$urandom_range(0, 3)];
        a0 = $urandom;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
